// File: rtl/mult_retire_pkg.sv
// mult_retire_pkg: shared types and constants for the multiplier retire path.
//   DEF_PPL_STAGE : default multiplier latency in cycles
//   REG_AW        : register-address width
//   mult_type_e   : multiply signedness codes
//   slot_t        : one tracking-pipeline slot
//   wb_ent_t      : one buffered writeback entry
package mult_retire_pkg;

    localparam int DEF_PPL_STAGE = 3;
    localparam int REG_AW        = 5;
    localparam int XLEN          = 32;

    typedef enum logic [1:0] {
        MULT_SXS = 2'b00,
        MULT_SXU = 2'b01,
        MULT_UXU = 2'b10,
        MULT_RSV = 2'b11   // reserved, retires as UxU
    } mult_type_e;

    typedef struct packed {
        logic              vld;
        mult_type_e        typ;
        logic              hi;
        logic [REG_AW-1:0] rd;
    } slot_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_ent_t;

    function automatic logic [XLEN-1:0] sel_half(input logic [63:0] p, input logic hi);
        return hi ? p[63:32] : p[31:0];
    endfunction

    function automatic logic [31:0] rd_onehot(input logic [REG_AW-1:0] rd);
        return 32'd1 << rd;
    endfunction

endpackage

// File: rtl/mult_retire_fifo.sv
// mult_retire_fifo: result buffer between the multiplier and writeback.
//   clk, rst      : clock, async active-low reset
//   flush         : empty the buffer on the next edge (wins over push)
//   push, push_ent: enqueue one result
//   pop_ready     : consumer accepts the head entry this cycle
//   head_vld/head : head entry (zeroed when empty)
//   cnt           : number of valid entries
//   ent_vld/ent_rd: per-entry valid and destination, for the busy mask
module mult_retire_fifo
    import mult_retire_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          push,
    input  wb_ent_t                       push_ent,
    input  logic                          pop_ready,
    output logic                          head_vld,
    output wb_ent_t                       head,
    output logic [$clog2(DEPTH):0]        cnt,
    output logic [DEPTH-1:0]              ent_vld,
    output logic [DEPTH-1:0][REG_AW-1:0]  ent_rd
);

    localparam int AW = $clog2(DEPTH);

    wb_ent_t [DEPTH-1:0] mem;
    logic    [AW-1:0]    wr_ptr, rd_ptr;
    logic                pop;

    assign head_vld = (cnt != '0);
    assign pop      = head_vld && pop_ready;
    assign head     = head_vld ? mem[rd_ptr] : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) ent_rd[i] = mem[i].rd;
    end

    // Pointers are AW bits wide, so wrap is the natural modulo-DEPTH overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem     <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ent_vld <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            ent_vld <= '0;
        end else begin
            // Clear on pop before set on push so a same-slot push survives.
            if (pop) begin
                ent_vld[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + 1'b1;
            end
            if (push) begin
                mem[wr_ptr]     <= push_ent;
                ent_vld[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + 1'b1;
            end
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

endmodule

// File: rtl/mult_retire.sv
// mult_retire: retire side of the pipelined multiplier.
// Tracks accepted multiplies through a MULT_PPL_STAGE-deep shift register,
// captures the selected product half when the last slot lines up with the
// multiplier output, buffers it, and hands it to writeback over valid/ready.
//   issue_*  : issue handshake and per-op fields; issue_ready_o is credit
//   p_*_i    : multiplier product outputs (SxS, SxU, UxU)
//   wb_*     : writeback handshake, rd and data of the head result
//   busy_mask_o : destinations with a result in flight or buffered
//   flush_i  : drop everything in flight and buffered on the next edge
module mult_retire
    import mult_retire_pkg::*;
#(
    parameter int MULT_PPL_STAGE = DEF_PPL_STAGE,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              issue_valid_i,
    output logic              issue_ready_o,
    input  logic [1:0]        issue_type_i,
    input  logic              issue_hi_i,
    input  logic [REG_AW-1:0] issue_rd_addr_i,
    input  logic [63:0]       p_sxs_i,
    input  logic [63:0]       p_sxu_i,
    input  logic [63:0]       p_uxu_i,
    output logic              wb_valid_o,
    input  logic              wb_ready_i,
    output logic [REG_AW-1:0] wb_rd_addr_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic [31:0]       busy_mask_o
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW  = $clog2(FIFO_DEPTH + MULT_PPL_STAGE + 1) + 1;

    slot_t [MULT_PPL_STAGE-1:0]          pipe;
    slot_t                               last;
    logic  [CW-1:0]                      inflight_cnt;
    logic  [FCW-1:0]                     fifo_cnt;
    logic                                fire, push;
    logic  [63:0]                        prod;
    wb_ent_t                             push_ent, head;
    logic  [FIFO_DEPTH-1:0]              ent_vld;
    logic  [FIFO_DEPTH-1:0][REG_AW-1:0]  ent_rd;

    // Credit counts every slot, including x0 ops, so the FIFO never overflows.
    assign issue_ready_o = (inflight_cnt + CW'(fifo_cnt)) < CW'(FIFO_DEPTH);
    assign fire          = issue_valid_i && issue_ready_o && !flush_i;

    assign last = pipe[MULT_PPL_STAGE-1];
    assign push = last.vld && (last.rd != '0);

    always_comb begin
        prod = p_uxu_i;
        case (last.typ)
            MULT_SXS: prod = p_sxs_i;
            MULT_SXU: prod = p_sxu_i;
            default:  prod = p_uxu_i;
        endcase
    end

    assign push_ent = '{rd: last.rd, data: sel_half(prod, last.hi)};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe         <= '0;
            inflight_cnt <= '0;
        end else begin
            pipe[0] <= '{vld: fire, typ: mult_type_e'(issue_type_i),
                         hi: issue_hi_i, rd: issue_rd_addr_i};
            for (int k = 1; k < MULT_PPL_STAGE; k++) pipe[k] <= pipe[k-1];
            if (flush_i) begin
                for (int k = 0; k < MULT_PPL_STAGE; k++) pipe[k].vld <= 1'b0;
                inflight_cnt <= '0;
            end else begin
                inflight_cnt <= inflight_cnt + CW'(fire) - CW'(last.vld);
            end
        end
    end

    mult_retire_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush_i),
        .push      (push),
        .push_ent  (push_ent),
        .pop_ready (wb_ready_i),
        .head_vld  (wb_valid_o),
        .head      (head),
        .cnt       (fifo_cnt),
        .ent_vld   (ent_vld),
        .ent_rd    (ent_rd)
    );

    assign wb_rd_addr_o = head.rd;
    assign wb_data_o    = head.data;

    always_comb begin
        busy_mask_o = '0;
        for (int k = 0; k < MULT_PPL_STAGE; k++)
            if (pipe[k].vld) busy_mask_o = busy_mask_o | rd_onehot(pipe[k].rd);
        for (int i = 0; i < FIFO_DEPTH; i++)
            if (ent_vld[i]) busy_mask_o = busy_mask_o | rd_onehot(ent_rd[i]);
        busy_mask_o[0] = 1'b0;
    end

endmodule
